// File: rtl/sna_axi_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// sna_axi_sequencer
//
// Slave-side NoC-to-AXI4-Lite sequencer. Collects a head/body/tail request
// packet from the router port, runs exactly one AXI4-Lite read or write, and
// returns a head/body/tail reply packet to the requesting node. Only one
// transaction is outstanding at a time.
//
// Ports
//   clk, rst                 system clock, asynchronous active-high reset
//   noc_in_data/valid/ready  request flits from router (37 bit)
//   noc_out_data/valid/ready reply flits to router (37 bit)
//   m_aw*, m_w*, m_b*        AXI4-Lite write address / data / response
//   m_ar*, m_r*              AXI4-Lite read address / data
//   busy                     high whenever not waiting for a request head
//   proto_err                one-cycle pulse per dropped flit / aborted packet
//
// Flit layout: [36:35] type (10 head, 00 body, 01 tail, 11 illegal).
//   Request head [32] read flag, [31:0] address; body [31:0] write data;
//   tail [3:0] requester id. Reply tail carries [3:0] requester id,
//   [5:4] AXI response, [9:6] NODE_ID.
//
// Every output is either a register or a decode of registers, so there is
// no combinational path from any handshake input to any output.
// -----------------------------------------------------------------------------
module sna_axi_sequencer #(
  parameter logic [3:0] NODE_ID = 4'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [36:0] noc_in_data,
  input  logic        noc_in_valid,
  output logic        noc_in_ready,
  output logic [36:0] noc_out_data,
  output logic        noc_out_valid,
  input  logic        noc_out_ready,
  output logic [31:0] m_awaddr,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic [1:0]  m_bresp,
  input  logic        m_bvalid,
  output logic        m_bready,
  output logic [31:0] m_araddr,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rvalid,
  output logic        m_rready,
  output logic        busy,
  output logic        proto_err
);

  typedef enum logic [3:0] {
    S_HEAD, S_BODY, S_TAIL, S_WR, S_WRESP, S_RD, S_RRESP,
    S_RPL_H, S_RPL_B, S_RPL_T
  } state_t;

  localparam logic [1:0] FT_HEAD = 2'b10;
  localparam logic [1:0] FT_BODY = 2'b00;
  localparam logic [1:0] FT_TAIL = 2'b01;

  state_t      r_state;
  state_t      w_next;
  logic        w_err;
  logic [1:0]  w_ftype;
  logic        w_aw_ok;
  logic        w_w_ok;
  logic        w_unused_bits;

  logic [31:0] r_addr;
  logic        r_is_read;
  logic [31:0] r_wdata;
  logic [3:0]  r_pov;
  logic [31:0] r_rdata;
  logic [1:0]  r_resp;
  logic        r_aw_done;
  logic        r_w_done;
  logic        r_proto_err;

  assign w_ftype       = noc_in_data[36:35];
  // Request bits [34:33] carry no information for this block.
  assign w_unused_bits = ^noc_in_data[34:33];

  // AW and W finish independently; each is done once its handshake has
  // happened either on an earlier edge or on the coming one.
  assign w_aw_ok = r_aw_done | m_awready;
  assign w_w_ok  = r_w_done  | m_wready;

  // NOTE: state and data registers use non-blocking assignments so every
  // flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_HEAD;
    else     r_state <= w_next;
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    w_next = r_state;
    w_err  = 1'b0;
    case (r_state)
      S_HEAD: if (noc_in_valid) begin
        if (w_ftype == FT_HEAD) w_next = S_BODY;
        else                    w_err  = 1'b1;   // stray flit dropped
      end
      S_BODY: if (noc_in_valid) begin
        case (w_ftype)
          FT_HEAD: begin w_next = S_BODY; w_err = 1'b1; end  // restart
          FT_BODY: w_next = S_TAIL;
          default: begin w_next = S_HEAD; w_err = 1'b1; end
        endcase
      end
      S_TAIL: if (noc_in_valid) begin
        case (w_ftype)
          FT_HEAD: begin w_next = S_BODY; w_err = 1'b1; end  // restart
          FT_TAIL: w_next = r_is_read ? S_RD : S_WR;
          default: begin w_next = S_HEAD; w_err = 1'b1; end
        endcase
      end
      S_WR:    if (w_aw_ok && w_w_ok) w_next = S_WRESP;
      S_WRESP: if (m_bvalid)          w_next = S_RPL_H;
      S_RD:    if (m_arready)         w_next = S_RRESP;
      S_RRESP: if (m_rvalid)          w_next = S_RPL_H;
      S_RPL_H: if (noc_out_ready)     w_next = S_RPL_B;
      S_RPL_B: if (noc_out_ready)     w_next = S_RPL_T;
      S_RPL_T: if (noc_out_ready)     w_next = S_HEAD;
      default: w_next = S_HEAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr      <= '0;
      r_is_read   <= 1'b0;
      r_wdata     <= '0;
      r_pov       <= '0;
      r_rdata     <= '0;
      r_resp      <= '0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      r_proto_err <= w_err;
      case (r_state)
        S_HEAD, S_BODY, S_TAIL: if (noc_in_valid) begin
          if (w_ftype == FT_HEAD) begin
            r_addr    <= noc_in_data[31:0];
            r_is_read <= noc_in_data[32];
          end else if (r_state == S_BODY && w_ftype == FT_BODY) begin
            r_wdata <= noc_in_data[31:0];
          end else if (r_state == S_TAIL && w_ftype == FT_TAIL) begin
            r_pov     <= noc_in_data[3:0];
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
          end
        end
        S_WR: begin
          if (m_awvalid && m_awready) r_aw_done <= 1'b1;
          if (m_wvalid  && m_wready)  r_w_done  <= 1'b1;
        end
        S_WRESP: if (m_bvalid) begin
          r_resp  <= m_bresp;
          r_rdata <= '0;
        end
        S_RRESP: if (m_rvalid) begin
          r_resp  <= m_rresp;
          r_rdata <= m_rdata;
        end
        default: ;
      endcase
    end
  end

  // Output decode from registers only.
  assign noc_in_ready  = (r_state == S_HEAD) || (r_state == S_BODY) ||
                         (r_state == S_TAIL);
  assign busy          = (r_state != S_HEAD);
  assign proto_err     = r_proto_err;

  assign m_awaddr      = r_addr;
  assign m_awvalid     = (r_state == S_WR) && !r_aw_done;
  assign m_wdata       = r_wdata;
  assign m_wstrb       = 4'hF;
  assign m_wvalid      = (r_state == S_WR) && !r_w_done;
  assign m_bready      = (r_state == S_WRESP);
  assign m_araddr      = r_addr;
  assign m_arvalid     = (r_state == S_RD);
  assign m_rready      = (r_state == S_RRESP);

  assign noc_out_valid = (r_state == S_RPL_H) || (r_state == S_RPL_B) ||
                         (r_state == S_RPL_T);

  always_comb begin
    noc_out_data = '0;
    case (r_state)
      S_RPL_H: noc_out_data = {2'b10, 2'b00, r_is_read, r_addr};
      S_RPL_B: noc_out_data = {2'b00, 3'b000, r_rdata};
      S_RPL_T: noc_out_data = {2'b01, 25'd0, NODE_ID, r_resp, r_pov};
      default: noc_out_data = '0;
    endcase
  end

endmodule
